rng_entropy_harvester: RTL and testbench

//  Consumer side of the ring-oscillator entropy array. Gates the oscillators and

---
 rtl/rng_entropy_harvester_if.sv | 25 ++
 rtl/rng_entropy_harvester.sv | 226 ++++++++++++++++++++++
 tb/tb_rng_entropy_harvester.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_entropy_harvester_if.sv
// Valid/ready word channel between the entropy harvester and the PS-facing
// register block.
//   rnd_data  : random word (held stable while rnd_valid is high)
//   rnd_valid : rnd_data holds an unconsumed word
//   rnd_ready : consumer accepts the word this cycle
// master = harvester side, slave = register block side.
interface rng_entropy_harvester_if #(
   parameter int WORD_WIDTH = 32
) ();
   logic [WORD_WIDTH-1:0] rnd_data;
   logic                  rnd_valid;
   logic                  rnd_ready;

   modport master (
      output rnd_data,
      output rnd_valid,
      input  rnd_ready
   );

   modport slave (
      input  rnd_data,
      input  rnd_valid,
      output rnd_ready
   );
endinterface

// File: rtl/rng_entropy_harvester.sv
// Consumer side of the ring-oscillator entropy array.
// Gates the oscillators, double-flop synchronises their outputs, XOR-compresses
// each sample to one raw bit, debiases with a von Neumann corrector, runs a
// repetition-count health test and packs debiased bits into words that are
// handed out over a valid/ready channel.
// Ports:
//   clk       : system clock
//   resetn    : synchronous active-low reset
//   enable    : level request to run the generator
//   ro_bits   : asynchronous ring-oscillator outputs
//   ro_enable : enable to every ring oscillator (WARMUP/RUN only)
//   fault     : health test failed, sticky until enable drops
//   rnd       : word channel (master modport: rnd_data, rnd_valid, rnd_ready)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | oscillators off, everything cleared, waiting for enable
// WARMUP | oscillators running, WARMUP_CYCLES settle time, no sampling
// RUN    | sampling every SAMPLE_DIV cycles, debias, health test, packing
// FAULT  | repetition limit hit; oscillators off, output word discarded
module rng_entropy_harvester #(
   parameter int NUMBITS       = 32,
   parameter int WORD_WIDTH    = 32,
   parameter int SAMPLE_DIV    = 4,
   parameter int WARMUP_CYCLES = 64,
   parameter int REPEAT_LIMIT  = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic [NUMBITS-1:0] ro_bits,
   output logic               ro_enable,
   output logic               fault,
   rng_entropy_harvester_if.master rnd
);

   localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int RUN_W  = $clog2(REPEAT_LIMIT + 1);
   localparam int CNT_W  = $clog2(WORD_WIDTH + 1);

   localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(REPEAT_LIMIT);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [NUMBITS-1:0]    sync_s1, sync_s2;
   logic                  raw;
   logic [WARM_W-1:0]     warm_cnt;
   logic [DIV_W-1:0]      div_cnt;
   logic                  tick;
   logic [RUN_W-1:0]      run_len, run_nxt;
   logic                  prev_raw;
   logic                  hit;
   logic                  phase;
   logic                  pair_bit;
   logic                  emit;
   logic [WORD_WIDTH-1:0] acc;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  acc_full;
   logic                  xfer;

   // Sampling datapath

   assign raw = ^sync_s2;

   // div_cnt is a down-counter loaded on RUN entry, so a terminal count of 0
   // lands on RUN cycle SAMPLE_DIV-1, SAMPLE_DIV-1+SAMPLE_DIV, ...
   assign tick = (state == ST_RUN) && (div_cnt == '0);

   // run_len == 0 marks the first tick after RUN entry.
   assign run_nxt = ((run_len == '0) || (raw != prev_raw)) ? RUN_W'(1)
                                                           : run_len + RUN_W'(1);
   assign hit     = tick && (run_nxt == RUN_LIMIT);

   // Second tick of a pair with differing bits emits the first bit of the pair
   // (01 -> 0, 10 -> 1). A tick that trips the health test never emits.
   assign emit     = tick && phase && (pair_bit != raw) && !hit;

   assign acc_full = (bit_cnt == CNT_FULL);
   assign xfer     = (state == ST_RUN) && enable && !hit && acc_full &&
                     (!rnd.rnd_valid || rnd.rnd_ready);

   // FSM

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ro_enable = 1'b0;
      fault     = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_WARMUP;
         end
         ST_WARMUP: begin
            ro_enable = 1'b1;
            if (warm_cnt == '0) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            ro_enable = 1'b1;
            if (hit) begin
               state_nxt = ST_FAULT;
            end
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (!enable) begin
         state_nxt = ST_IDLE;
      end
   end

   // Synchroniser: ring oscillators are asynchronous to clk.

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= ro_bits;
         sync_s2 <= sync_s1;
      end
   end

   // Timers

   always_ff @(posedge clk) begin
      if (!resetn) begin
         warm_cnt <= '0;
         div_cnt  <= '0;
      end else begin
         if (state == ST_IDLE) begin
            warm_cnt <= WARM_LOAD;
         end else if ((state == ST_WARMUP) && (warm_cnt != '0)) begin
            warm_cnt <= warm_cnt - WARM_W'(1);
         end

         if (!enable || (state != ST_RUN) || (div_cnt == '0)) begin
            div_cnt <= DIV_LOAD;
         end else begin
            div_cnt <= div_cnt - DIV_W'(1);
         end
      end
   end

   // Health test and von Neumann pairing

   always_ff @(posedge clk) begin
      if (!resetn) begin
         run_len  <= '0;
         prev_raw <= 1'b0;
         phase    <= 1'b0;
         pair_bit <= 1'b0;
      end else if (!enable || (state != ST_RUN)) begin
         run_len  <= '0;
         prev_raw <= 1'b0;
         phase    <= 1'b0;
         pair_bit <= 1'b0;
      end else if (tick) begin
         run_len  <= run_nxt;
         prev_raw <= raw;
         phase    <= ~phase;
         if (!phase) begin
            pair_bit <= raw;
         end
      end
   end

   // Packing and output handshake

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc           <= '0;
         bit_cnt       <= '0;
         rnd.rnd_data  <= '0;
         rnd.rnd_valid <= 1'b0;
      end else if (!enable || (state != ST_RUN) || hit) begin
         // Leaving RUN (abort or fault) discards any partial or pending word;
         // rnd_data itself keeps its last value.
         acc           <= '0;
         bit_cnt       <= '0;
         rnd.rnd_valid <= 1'b0;
      end else if (xfer) begin
         rnd.rnd_data  <= acc;
         rnd.rnd_valid <= 1'b1;
         if (emit) begin
            acc     <= {acc[WORD_WIDTH-2:0], pair_bit};
            bit_cnt <= CNT_W'(1);
         end else begin
            bit_cnt <= '0;
         end
      end else begin
         if (rnd.rnd_valid && rnd.rnd_ready) begin
            rnd.rnd_valid <= 1'b0;
         end
         // A full accumulator that cannot hand off drops new bits.
         if (emit && !acc_full) begin
            acc     <= {acc[WORD_WIDTH-2:0], pair_bit};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rng_entropy_harvester.sv
// Testbench for rng_entropy_harvester: directed scenarios (reset, warmup,
// debias, backpressure, fault, abort) with a cycle-level behavioural model
// built from queues and plain counters, compared against the DUT every cycle,
// plus hand-computed literal expectations.
module tb_rng_entropy_harvester;

   localparam int NB = 32;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int WU = 64;
   localparam int RL = 32;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          enable = 1'b0;
   logic [NB-1:0] ro_bits = '0;
   logic          ro_enable;
   logic          fault;

   rng_entropy_harvester_if #(.WORD_WIDTH(W)) rif ();

   rng_entropy_harvester #(
      .NUMBITS(NB), .WORD_WIDTH(W), .SAMPLE_DIV(D),
      .WARMUP_CYCLES(WU), .REPEAT_LIMIT(RL)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .enable(enable),
      .ro_bits(ro_bits),
      .ro_enable(ro_enable),
      .fault(fault),
      .rnd(rif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   // 0: 0,1,1,0 per tick   1: constant 32'h1   2: pattern 0 for 64 ticks then 3
   // 3: 0,1,0,1,1,0,1,0 per tick
   int pat = 0;

   // Behavioural model
   int         m_mode = 0;  // 0 idle, 1 warmup, 2 run, 3 fault
   int         m_cnt = 0;   // cycles spent in current mode
   bit         q1 = 1'b0, q2 = 1'b0;
   int         m_run = 0;
   bit         m_prev = 1'b0;
   bit         m_phase = 1'b0;
   bit         m_pair = 1'b0;
   int         m_sym = 0;   // ticks since RUN entry
   bit         m_bits[$];
   bit         m_valid = 1'b0;
   logic [W-1:0] m_data = '0;

   function automatic logic [W-1:0] pack_bits();
      logic [W-1:0] v;
      v = '0;
      foreach (m_bits[i]) v = {v[W-2:0], m_bits[i]};
      return v;
   endfunction

   function automatic bit sym_of(int p, int k);
      bit [3:0] alt;
      bit [7:0] pb;
      alt = 4'b0110;
      pb  = 8'b01011010;
      if (p == 0 || (p == 2 && k < 64)) return alt[k % 4];
      return pb[k % 8];
   endfunction

   function automatic logic [NB-1:0] with_parity(bit s);
      logic [NB-1:0] v;
      v = NB'($urandom);
      if ((^v) != s) v[5] = ~v[5];
      return v;
   endfunction

   task automatic model_clear();
      m_run   = 0;
      m_prev  = 1'b0;
      m_phase = 1'b0;
      m_pair  = 1'b0;
      m_sym   = 0;
      m_bits.delete();
      m_valid = 1'b0;
   endtask

   initial begin : model
      bit raw, tick, hit, emit, eb;
      int rn;
      forever begin
         @(posedge clk);
         raw = q2;
         q2  = q1;
         q1  = ^ro_bits;
         if (!resetn) begin
            q1 = 1'b0;
            q2 = 1'b0;
            m_mode = 0;
            m_cnt  = 0;
            model_clear();
            m_data = '0;
         end else if (!enable) begin
            m_mode = 0;
            m_cnt  = 0;
            model_clear();
         end else begin
            case (m_mode)
               0: begin
                  m_mode = 1;
                  m_cnt  = 0;
               end
               1: begin
                  m_cnt++;
                  if (m_cnt == WU) begin
                     m_mode = 2;
                     m_cnt  = 0;
                     model_clear();
                  end
               end
               2: begin
                  tick = ((m_cnt % D) == D - 1);
                  m_cnt++;
                  hit  = 1'b0;
                  emit = 1'b0;
                  eb   = 1'b0;
                  if (tick) begin
                     m_sym++;
                     rn = (m_run == 0 || raw != m_prev) ? 1 : m_run + 1;
                     m_run  = rn;
                     m_prev = raw;
                     if (rn == RL) begin
                        hit = 1'b1;
                     end else if (!m_phase) begin
                        m_pair  = raw;
                        m_phase = 1'b1;
                     end else begin
                        m_phase = 1'b0;
                        if (m_pair != raw) begin
                           emit = 1'b1;
                           eb   = m_pair;
                        end
                     end
                  end
                  if (hit) begin
                     m_mode  = 3;
                     m_valid = 1'b0;
                     m_bits.delete();
                  end else begin
                     if (m_bits.size() == W && (!m_valid || rif.rnd_ready)) begin
                        m_data  = pack_bits();
                        m_valid = 1'b1;
                        m_bits.delete();
                     end else if (m_valid && rif.rnd_ready) begin
                        m_valid = 1'b0;
                     end
                     if (emit && m_bits.size() < W) m_bits.push_back(eb);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ro_bits driver: present the symbol for the next tick right after each tick.
   initial begin : driver
      forever begin
         @(negedge clk);
         if (pat == 1) ro_bits = 32'h0000_0001;
         else ro_bits = with_parity(sym_of(pat, m_sym));
      end
   end

   initial begin : compare
      logic [W+2:0] act, exp;
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            act = {ro_enable, fault, rif.rnd_valid, rif.rnd_data};
            exp = {(m_mode == 1 || m_mode == 2), (m_mode == 3), m_valid, m_data};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL cycle_model t=%0t ro_en/fault/valid/data got %b/%b/%b/%h want %b/%b/%b/%h",
                        $time, act[W+2], act[W+1], act[W], act[W-1:0],
                        exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
            end
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise enable, check ro_enable next cycle, count cycles until rnd_valid.
   task automatic start_run(output int n);
      enable = 1'b1;
      @(negedge clk);
      chk("ro_enable_on", ro_enable, 1);
      n = 1;
      while (!rif.rnd_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin : main
      int n;
      rif.rnd_ready = 1'b0;
      enable = 1'b1;
      resetn = 1'b0;

      // reset with enable held high
      @(negedge clk);
      cmp_on = 1'b1;
      cyc(2);
      chk("rst_ro_enable", ro_enable, 0);
      chk("rst_valid", rif.rnd_valid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_data", rif.rnd_data, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rel_ro_enable", ro_enable, 1);

      // enable toggle, then warmup + debias with pattern 0110
      enable = 1'b0;
      cyc(3);
      chk("idle_ro_enable", ro_enable, 0);
      pat = 2;
      start_run(n);
      // valid on RUN cycle 257 = 64 warmup + 258 cycles after enable
      chk("first_word_latency", n, 322);
      chk("word1_data", rif.rnd_data, 32'h5555_5555);
      chk("word1_no_fault", fault, 0);

      // backpressure: second word completes and stalls
      n = 0;
      while (m_bits.size() != W && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("word2_filled", m_bits.size(), W);
      cyc(30);
      chk("stall_valid", rif.rnd_valid, 1);
      chk("stall_data", rif.rnd_data, 32'h5555_5555);
      rif.rnd_ready = 1'b1;
      @(negedge clk);
      rif.rnd_ready = 1'b0;
      chk("word2_valid", rif.rnd_valid, 1);
      chk("word2_data", rif.rnd_data, 32'h3333_3333);
      cyc(20);
      chk("word2_held", rif.rnd_data, 32'h3333_3333);

      // health-test fault with constant raw bit
      enable = 1'b0;
      pat = 1;
      cyc(2);
      chk("abort_valid", rif.rnd_valid, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("fault_ro_enable_on", ro_enable, 1);
      n = 1;
      while (!fault && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("fault_latency", n, 193);
      chk("fault_ro_enable", ro_enable, 0);
      chk("fault_valid", rif.rnd_valid, 0);
      cyc(5);
      chk("fault_sticky", fault, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("fault_cleared", fault, 0);
      chk("fault_idle_ro", ro_enable, 0);

      // abort after 10 packed bits, restart yields only fresh bits
      pat = 0;
      rif.rnd_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (m_bits.size() != 10 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_bits", m_bits.size(), 10);
      enable = 1'b0;
      cyc(2);
      start_run(n);
      chk("restart_latency", n, 322);
      chk("restart_data", rif.rnd_data, 32'h5555_5555);

      // second pattern, then random consumer readiness
      enable = 1'b0;
      pat = 3;
      cyc(2);
      rif.rnd_ready = 1'b0;
      start_run(n);
      chk("patb_latency", n, 322);
      chk("patb_data", rif.rnd_data, 32'h3333_3333);
      repeat (800) begin
         @(negedge clk);
         rif.rnd_ready = 1'($urandom_range(0, 1));
      end
      chk("patb_no_fault", fault, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
